// File: rtl/ysyx_25060173_ifu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ysyx_25060173_ifu                                             |
// | Purpose  : Instruction fetch unit. One fetch is in flight at a time. The |
// |            unit requests a word, waits for the response, and holds it    |
// |            for the decoder. It handles redirects and halt.               |
// | Option   : YSYX_25060173_IFU_MISALIGN_CHECK_EN                           |
// |            When defined, a misaligned redirect target sets the sticky    |
// |            fetch_err flag and halts. When undefined, the low two target  |
// |            bits are cleared and fetch_err is tied low.                   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module ysyx_25060173_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        fetch_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_HALT = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nx;
  logic        r_pend_valid;
  logic        w_pend_valid_nx;
  logic [31:0] r_pend_pc;
  logic [31:0] w_pend_pc_nx;
  logic        r_halt_pend;
  logic        w_halt_pend_nx;
  logic [31:0] r_out_inst;
  logic [31:0] w_out_inst_nx;
  logic [31:0] r_out_pc;
  logic [31:0] w_out_pc_nx;

  logic        w_misalign;
  logic [31:0] w_redir_tgt;
  logic        w_redir_ok;
  logic        w_redir_any;
  logic [31:0] w_redir_pc;
  logic        w_stop;
  logic        w_req_fire;

`ifdef YSYX_25060173_IFU_MISALIGN_CHECK_EN
  assign w_misalign  = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign w_redir_tgt = redirect_pc;
`else
  assign w_misalign  = 1'b0;
  assign w_redir_tgt = redirect_pc & 32'hFFFF_FFFC;
`endif

  // A usable redirect this cycle. A misaligned one becomes a halt instead.
  assign w_redir_ok  = redirect_valid && !w_misalign;
  // A redirect is either waiting in the pending register or arriving now.
  // The newest target wins.
  assign w_redir_any = r_pend_valid || w_redir_ok;
  assign w_redir_pc  = w_redir_ok ? w_redir_tgt : r_pend_pc;
  // Any reason to stop fetching: halt now, halt earlier, or a bad target.
  assign w_stop      = r_halt_pend || halt || w_misalign;

  // Do not request once a halt is pending, so no fetch is issued for it.
  assign imem_req_valid = (r_state == S_REQ) && !r_halt_pend;
  // The request address comes straight from the PC register.
  // It cannot change while a request is waiting to be accepted.
  assign imem_req_addr  = r_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;
  assign out_valid      = (r_state == S_HOLD);
  assign out_inst       = r_out_inst;
  assign out_pc         = r_out_pc;

  // State register and fetch datapath; reset abandons any transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_pend_valid <= 1'b0;
      r_pend_pc    <= 32'h0000_0000;
      r_halt_pend  <= 1'b0;
      r_out_inst   <= 32'h0000_0000;
      r_out_pc     <= 32'h0000_0000;
    end else begin
      r_state      <= w_state_nx;
      r_pc         <= w_pc_nx;
      r_pend_valid <= w_pend_valid_nx;
      r_pend_pc    <= w_pend_pc_nx;
      r_halt_pend  <= w_halt_pend_nx;
      r_out_inst   <= w_out_inst_nx;
      r_out_pc     <= w_out_pc_nx;
    end
  end

  // Next-state and datapath decisions for the fetch sequence.
  always_comb begin
    w_state_nx      = r_state;
    w_pc_nx         = r_pc;
    w_pend_valid_nx = r_pend_valid;
    w_pend_pc_nx    = r_pend_pc;
    w_halt_pend_nx  = r_halt_pend;
    w_out_inst_nx   = r_out_inst;
    w_out_pc_nx     = r_out_pc;

    // Sample redirect and halt in every live state. A state consumes the
    // pending redirect only when it can act on it.
    if (r_state != S_HALT) begin
      if (w_redir_ok) begin
        w_pend_valid_nx = 1'b1;
        w_pend_pc_nx    = w_redir_tgt;
      end
      if (halt || w_misalign) begin
        w_halt_pend_nx = 1'b1;
      end
    end

    case (r_state)
      S_IDLE: begin
        w_state_nx = S_REQ;
        // No request is issued yet, so a redirect can go straight to the PC.
        if (w_redir_any) begin
          w_pc_nx         = w_redir_pc;
          w_pend_valid_nx = 1'b0;
        end
      end

      S_REQ: begin
        // Keep the address stable while the request waits. A redirect stays
        // pending, and the word it fetches is thrown away later.
        if (w_req_fire) begin
          w_state_nx = S_WAIT;
        end else if (w_stop) begin
          w_state_nx = S_HALT;
        end
      end

      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (w_stop) begin
            w_state_nx = S_HALT;
          end else if (w_redir_any) begin
            // This word was fetched before the redirect, so drop it.
            w_pc_nx         = w_redir_pc;
            w_pend_valid_nx = 1'b0;
            w_state_nx      = S_REQ;
          end else begin
            w_out_inst_nx = imem_rsp_data;
            w_out_pc_nx   = r_pc;
            w_state_nx    = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (w_stop) begin
          w_state_nx = S_HALT;
        end else if (w_redir_any) begin
          // The redirect target wins over pc+4, even when the decoder
          // accepts the held word in this same cycle.
          w_pc_nx         = w_redir_pc;
          w_pend_valid_nx = 1'b0;
          w_state_nx      = S_REQ;
        end else if (out_ready) begin
          w_pc_nx    = r_pc + 32'd4;
          w_state_nx = S_REQ;
        end
      end

      S_HALT: begin
        w_state_nx = S_HALT;
      end

      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

`ifdef YSYX_25060173_IFU_MISALIGN_CHECK_EN
  logic r_fetch_err;

  // Sticky error flag: set by a misaligned redirect target, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_err <= 1'b0;
    end else if ((r_state != S_HALT) && w_misalign) begin
      r_fetch_err <= 1'b1;
    end
  end

  assign fetch_err = r_fetch_err;
`else
  assign fetch_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25060173_ifu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ysyx_25060173_ifu                                          |
// | Purpose  : Directed testbench for ysyx_25060173_ifu. Expected request    |
// |            and delivery addresses sit in queues. Instruction words come  |
// |            from an address-derived memory function. A monitor checks     |
// |            every handshake and the hold-stability rules.                 |
// | Option   : YSYX_25060173_IFU_MISALIGN_CHECK_EN selects misalign checks.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_ysyx_25060173_ifu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt = 1'b0;
  logic        fetch_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_req[$];
  logic [31:0] exp_out[$];

  logic        stray    = 1'b0;
  logic        rsp_due  = 1'b0;
  logic [31:0] rsp_addr = 32'h0;

  always #5 clk = ~clk;

  ysyx_25060173_ifu #(.RESET_PC(32'h8000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .fetch_err      (fetch_err)
  );

  // Memory contents: low address bits shifted up, with an addi-like opcode.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[23:0], 8'h13};
  endfunction

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk(act === exp, nm, act, exp);
  endtask

  // Move to the drive point just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Wait for an out_valid or a request handshake, with a cycle limit.
  // On success the task ends at the falling edge where the event was seen.
  task automatic wait_evt(input bit want_out, input int budget, input string nm);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      seen = want_out ? out_valid : (imem_req_valid && imem_req_ready);
      if (!seen) tick();
    end
    chk(seen, nm, {31'b0, seen}, 32'd1);
  endtask

  // Assert reset between clock edges; the outputs must clear with no edge.
  task automatic do_reset();
    chk_eq("exp_req drained", exp_req.size(), 0);
    chk_eq("exp_out drained", exp_out.size(), 0);
    exp_req.delete();
    exp_out.delete();
    rst            = 1'b1;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clk);
    chk_eq("rst req_valid", imem_req_valid, 0);
    chk_eq("rst out_valid", out_valid, 0);
    chk_eq("rst out_inst", out_inst, 0);
    chk_eq("rst out_pc", out_pc, 0);
    chk_eq("rst fetch_err", fetch_err, 0);
    tick();
    rst = 1'b0;
  endtask

  // Memory: answer each accepted request on the next cycle. It can also
  // send a stray response when no request is outstanding.
  always @(negedge clk) begin
    rsp_due  = !rst && imem_req_valid && imem_req_ready;
    rsp_addr = imem_req_addr;
  end

  always @(posedge clk) begin
    #1;
    if (rsp_due) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(rsp_addr);
    end else if (stray) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  end

  // Monitor: handshakes against the expectation queues, plus stability rules.
  logic        p_req_wait = 1'b0;
  logic        p_hold     = 1'b0;
  logic        p_quiet    = 1'b0;
  logic [31:0] p_addr     = 32'h0;
  logic [31:0] p_inst     = 32'h0;
  logic [31:0] p_pc       = 32'h0;

  always @(negedge clk) begin
    if (rst) begin
      p_req_wait = 1'b0;
      p_hold     = 1'b0;
    end else begin
      if (p_req_wait && p_quiet) begin
        chk_eq("req_valid held until accepted", imem_req_valid, 1);
        chk_eq("req_addr stable until accepted", imem_req_addr, p_addr);
      end
      if (p_hold && p_quiet) begin
        chk_eq("out_valid held", out_valid, 1);
        chk_eq("out_inst held", out_inst, p_inst);
        chk_eq("out_pc held", out_pc, p_pc);
      end
      if (imem_req_valid && imem_req_ready) begin
        chk(exp_req.size() != 0, "request expected", imem_req_addr, 32'h0);
        if (exp_req.size() != 0) chk_eq("req_addr", imem_req_addr, exp_req.pop_front());
      end
      if (out_valid && out_ready) begin
        chk(exp_out.size() != 0, "delivery expected", out_pc, 32'h0);
        if (exp_out.size() != 0) chk_eq("out_pc", out_pc, exp_out.pop_front());
        chk_eq("out_inst matches memory", out_inst, mem_word(out_pc));
      end
      p_req_wait = imem_req_valid && !imem_req_ready;
      p_hold     = out_valid && !out_ready;
      p_quiet    = !redirect_valid && !halt;
      p_addr     = imem_req_addr;
      p_inst     = out_inst;
      p_pc       = out_pc;
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();

    // First fetch with zero-wait memory, then hold for five cycles.
    exp_req.push_back(32'h8000_0000);
    exp_req.push_back(32'h8000_0004);
    exp_out.push_back(32'h8000_0000);
    @(negedge clk);
    chk_eq("idle req_valid", imem_req_valid, 0);
    tick(); @(negedge clk);
    chk_eq("first req_valid", imem_req_valid, 1);
    chk_eq("first req_addr", imem_req_addr, 32'h8000_0000);
    tick(); @(negedge clk);
    chk_eq("wait out_valid", out_valid, 0);
    tick(); @(negedge clk);
    chk_eq("hold out_valid", out_valid, 1);
    chk_eq("hold out_inst", out_inst, 32'h0000_0013);
    chk_eq("hold out_pc", out_pc, 32'h8000_0000);
    for (int i = 0; i < 5; i++) begin
      tick(); @(negedge clk);
      chk_eq("stall out_inst", out_inst, 32'h0000_0013);
      chk_eq("stall out_pc", out_pc, 32'h8000_0000);
      chk_eq("stall no request", imem_req_valid, 0);
    end
    tick(); out_ready = 1'b1;
    @(negedge clk);
    tick(); out_ready = 1'b0;
    wait_evt(1'b0, 4, "request after consume");
    chk_eq("sequential req_addr", imem_req_addr, 32'h8000_0004);
    tick();

    // Reset during the wait. Stray responses after release are ignored.
    // Redirect while the request is stalled; the stalled fetch is dropped.
    do_reset();
    imem_req_ready = 1'b0;
    stray          = 1'b1;
    out_ready      = 1'b1;
    exp_req.push_back(32'h8000_0000);
    exp_req.push_back(32'h8000_0100);
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      tick();
      redirect_valid = (k == 2);
      redirect_pc    = 32'h8000_0100;
      if (k == 3) stray = 1'b0;
      @(negedge clk);
      chk_eq("stalled req_valid", imem_req_valid, 1);
      chk_eq("stalled req_addr", imem_req_addr, 32'h8000_0000);
    end
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    wait_evt(1'b0, 2, "stalled request accepted");
    chk_eq("accepted stale addr", imem_req_addr, 32'h8000_0000);
    tick();
    wait_evt(1'b0, 4, "redirected request");
    chk_eq("redirect req_addr", imem_req_addr, 32'h8000_0100);
    tick(); out_ready = 1'b0;
    exp_out.push_back(32'h8000_0100);

    // Redirect in the same cycle as the decoder handshake: target wins.
    exp_req.push_back(32'h8000_0040);
    wait_evt(1'b1, 4, "hold 8000_0100");
    tick();
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0040;
    @(negedge clk);
    tick();
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    wait_evt(1'b0, 4, "request after hold redirect");
    chk_eq("hold redirect req_addr", imem_req_addr, 32'h8000_0040);
    exp_out.push_back(32'h8000_0040);
    tick();

    // Redirect to a misaligned target.
    wait_evt(1'b1, 4, "hold 8000_0040");
    tick();
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0042;
`ifndef YSYX_25060173_IFU_MISALIGN_CHECK_EN
    exp_req.push_back(32'h8000_0040);
`endif
    @(negedge clk);
    tick();
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
`ifdef YSYX_25060173_IFU_MISALIGN_CHECK_EN
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk_eq("misalign no request", imem_req_valid, 0);
      chk_eq("misalign fetch_err", fetch_err, 1);
      tick();
    end
`else
    wait_evt(1'b0, 4, "request after misaligned redirect");
    chk_eq("forced-aligned req_addr", imem_req_addr, 32'h8000_0040);
    chk_eq("fetch_err tied low", fetch_err, 0);
    tick();
`endif

    // Halt with a decoder handshake stops fetching until reset.
    do_reset();
    exp_req.push_back(32'h8000_0000);
    exp_out.push_back(32'h8000_0000);
    wait_evt(1'b1, 6, "hold after reset");
    tick();
    out_ready = 1'b1;
    halt      = 1'b1;
    @(negedge clk);
    tick();
    halt = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk_eq("halt req_valid", imem_req_valid, 0);
      chk_eq("halt out_valid", out_valid, 0);
      tick();
    end
    out_ready = 1'b0;
    do_reset();
    exp_req.push_back(32'h8000_0000);
    wait_evt(1'b0, 4, "restart request");
    chk_eq("restart req_addr", imem_req_addr, 32'h8000_0000);
    tick();
    chk_eq("final exp_req drained", exp_req.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
